// File: rtl/muldiv_iter.sv
// rtl/muldiv_iter.sv - iterative MULT/MULTU/DIV/DIVU unit, {HI,LO} result; MULDIV_DIV0_FAST_EN shortcuts divide by zero
module muldiv_iter #(
    parameter int WIDTH = 32,
    parameter int CNT_W = $clog2(WIDTH) + 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 op_div,
    input  logic                 op_signed,
    input  logic                 annul,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 stall,
    output logic                 done,
    output logic [2*WIDTH-1:0]   result
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

`ifdef MULDIV_DIV0_FAST_EN
    localparam bit DIV0_FAST = 1'b1;
`else
    localparam bit DIV0_FAST = 1'b0;
`endif

    logic [1:0]         state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH:0]     hi;
    logic [WIDTH-1:0]   lo;
    logic [WIDTH-1:0]   mcand;
    logic               is_div;
    logic               neg_q;
    logic               neg_r;
    logic               div0;

    logic               sign_a;
    logic               sign_b;
    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic               b_zero;

    logic [WIDTH:0]     mul_sum;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH+1:0]   div_diff;
    logic               div_ge;
    logic [WIDTH:0]     hi_next;
    logic [WIDTH-1:0]   lo_next;

    logic [2*WIDTH-1:0] mag;
    logic [2*WIDTH-1:0] prod_fix;
    logic [WIDTH-1:0]   quo_fix;
    logic [WIDTH-1:0]   rem_fix;
    logic [2*WIDTH-1:0] result_fix;

    // Magnitudes of the most-negative value wrap to 2^(WIDTH-1), which is the correct unsigned magnitude.
    always_comb begin
        sign_a = op_signed & a[WIDTH-1];
        sign_b = op_signed & b[WIDTH-1];
        a_mag  = sign_a ? -a : a;
        b_mag  = sign_b ? -b : b;
        b_zero = (b == '0);
    end

    // mul: {hi,lo} is the shift-right product register; div: hi is the partial remainder, lo shifts
    // the dividend out and the quotient bits in.
    always_comb begin
        mul_sum   = hi + {1'b0, (lo[0] ? mcand : {WIDTH{1'b0}})};
        div_shift = {hi[WIDTH-1:0], lo[WIDTH-1]};
        div_diff  = {1'b0, div_shift} - {2'b00, mcand};
        div_ge    = ~div_diff[WIDTH+1];
        if (is_div) begin
            hi_next = div_ge ? div_diff[WIDTH:0] : div_shift;
            lo_next = {lo[WIDTH-2:0], div_ge};
        end else begin
            hi_next = {1'b0, mul_sum[WIDTH:1]};
            lo_next = {mul_sum[0], lo[WIDTH-1:1]};
        end
    end

    // Divide by zero leaves the dividend magnitude in hi, so the remainder sign fix restores a exactly.
    always_comb begin
        mag        = {hi[WIDTH-1:0], lo};
        prod_fix   = neg_q ? -mag : mag;
        quo_fix    = div0 ? {WIDTH{1'b1}} : (neg_q ? -lo : lo);
        rem_fix    = neg_r ? -hi[WIDTH-1:0] : hi[WIDTH-1:0];
        result_fix = is_div ? {rem_fix, quo_fix} : prod_fix;
    end

    assign stall = (start & (state == S_IDLE) & ~annul) | busy;

    always_ff @(posedge clk) begin
        if (!rst) begin
            state  <= S_IDLE;
            cnt    <= '0;
            hi     <= '0;
            lo     <= '0;
            mcand  <= '0;
            is_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
            div0   <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
            result <= '0;
        end else begin
            busy <= (state == S_CALC) || (state == S_FIX);
            done <= (state == S_DONE);
            case (state)
                S_IDLE: begin
                    if (start && !annul) begin
                        is_div <= op_div;
                        neg_q  <= sign_a ^ sign_b;
                        neg_r  <= sign_a;
                        div0   <= op_div & b_zero;
                        cnt    <= '0;
                        if (op_div) begin
                            lo    <= a_mag;
                            mcand <= b_mag;
                            hi    <= (DIV0_FAST && b_zero) ? {1'b0, a_mag} : '0;
                        end else begin
                            lo    <= b_mag;
                            mcand <= a_mag;
                            hi    <= '0;
                        end
                        state <= (DIV0_FAST && op_div && b_zero) ? S_FIX : S_CALC;
                    end
                end
                S_CALC: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        hi  <= hi_next;
                        lo  <= lo_next;
                        cnt <= cnt + 1'b1;
                        if (cnt == CNT_W'(WIDTH - 1)) begin
                            state <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    if (annul) begin
                        state <= S_IDLE;
                    end else begin
                        result <= result_fix;
                        state  <= S_DONE;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_iter.sv
// tb/tb_muldiv_iter.sv - directed self-checking bench for muldiv_iter (WIDTH=32 and WIDTH=8)
module tb_muldiv_iter;

`ifdef MULDIV_DIV0_FAST_EN
    localparam int DIV0_LAT = 2;
`else
    localparam int DIV0_LAT = 34;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic        op_div;
    logic        op_signed;
    logic        annul;
    logic [31:0] a;
    logic [31:0] b;
    logic        busy;
    logic        stall;
    logic        done;
    logic [63:0] result;

    logic        start8;
    logic        op_div8;
    logic        op_signed8;
    logic        annul8;
    logic [7:0]  a8;
    logic [7:0]  b8;
    logic        busy8;
    logic        stall8;
    logic        done8;
    logic [15:0] result8;

    int checks;
    int errors;

    muldiv_iter #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .start(start), .op_div(op_div), .op_signed(op_signed),
        .annul(annul), .a(a), .b(b), .busy(busy), .stall(stall), .done(done), .result(result)
    );

    muldiv_iter #(.WIDTH(8)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .op_div(op_div8), .op_signed(op_signed8),
        .annul(annul8), .a(a8), .b(b8), .busy(busy8), .stall(stall8), .done(done8), .result(result8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Called 1 time unit after a rising edge with the DUT idle; returns edges from acceptance to done.
    task automatic run_op(input logic d, input logic s, input logic [31:0] aa, input logic [31:0] bb,
                          output int lat, output int busy_cyc, output logic [63:0] res);
        op_div = d; op_signed = s; a = aa; b = bb; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; a = $urandom; b = $urandom;
        lat = -1; busy_cyc = 0; res = '0;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (busy) busy_cyc++;
            if (done) begin
                lat = k; res = result;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %0b want 0", done); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL reset_result got %h want 0", result); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got %0b want 0", stall); end
        rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_mul();
        int lat, bc;
        logic [63:0] r;
        run_op(1'b0, 1'b1, 32'hFFFFFFFD, 32'd5, lat, bc, r);
        checks++; if (r !== 64'hFFFFFFFF_FFFFFFF1) begin errors++; $display("FAIL mult_neg3x5 got %h want FFFFFFFFFFFFFFF1", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL mult_latency got %0d want 34", lat); end
        checks++; if (bc !== 33) begin errors++; $display("FAIL mult_busy_cycles got %0d want 33", bc); end
        @(posedge clk); #1;
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_single_pulse got %0b want 0", done); end
        run_op(1'b0, 1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, lat, bc, r);
        checks++; if (r !== 64'hFFFFFFFE_00000001) begin errors++; $display("FAIL multu_max got %h want FFFFFFFE00000001", r); end
    endtask

    task automatic test_div();
        int lat, bc;
        logic [63:0] r;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, bc, r);
        checks++; if (r !== 64'h00000002_0000000E) begin errors++; $display("FAIL divu_100_7 got %h want 000000020000000E", r); end
        checks++; if (lat !== 34) begin errors++; $display("FAIL div_latency got %0d want 34", lat); end
        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd2, lat, bc, r);
        checks++; if (r !== 64'hFFFFFFFF_FFFFFFFD) begin errors++; $display("FAIL div_neg7_2 got %h want FFFFFFFFFFFFFFFD", r); end
        run_op(1'b1, 1'b1, 32'd7, 32'hFFFFFFFE, lat, bc, r);
        checks++; if (r !== 64'h00000001_FFFFFFFD) begin errors++; $display("FAIL div_7_neg2 got %h want 00000001FFFFFFFD", r); end
        run_op(1'b1, 1'b1, 32'h80000000, 32'hFFFFFFFF, lat, bc, r);
        checks++; if (r !== 64'h00000000_80000000) begin errors++; $display("FAIL div_min_neg1 got %h want 0000000080000000", r); end
    endtask

    task automatic test_div_zero();
        int lat, bc;
        logic [63:0] r;
        run_op(1'b1, 1'b0, 32'h12345678, 32'd0, lat, bc, r);
        checks++; if (r !== 64'h12345678_FFFFFFFF) begin errors++; $display("FAIL divu_by_zero got %h want 12345678FFFFFFFF", r); end
        checks++; if (lat !== DIV0_LAT) begin errors++; $display("FAIL div0_latency got %0d want %0d", lat, DIV0_LAT); end
        run_op(1'b1, 1'b1, 32'hFFFFFFF9, 32'd0, lat, bc, r);
        checks++; if (r !== 64'hFFFFFFF9_FFFFFFFF) begin errors++; $display("FAIL div_signed_by_zero got %h want FFFFFFF9FFFFFFFF", r); end
    endtask

    task automatic test_annul();
        int lat, bc;
        logic [63:0] r;
        run_op(1'b1, 1'b0, 32'd100, 32'd7, lat, bc, r);
        op_div = 1'b1; op_signed = 1'b1; a = 32'hFFFFFFF9; b = 32'd2; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (9) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_busy got %0b want 0", busy); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL annul_stall got %0b want 0", stall); end
        checks++; if (result !== 64'h00000002_0000000E) begin errors++; $display("FAIL annul_result_kept got %h want 000000020000000E", result); end
        run_op(1'b1, 1'b0, 32'd50, 32'd5, lat, bc, r);
        checks++; if (lat !== 34) begin errors++; $display("FAIL annul_restart_latency got %0d want 34", lat); end
        checks++; if (r !== 64'h00000000_0000000A) begin errors++; $display("FAIL annul_restart_result got %h want 000000000000000A", r); end
    endtask

    task automatic test_annul_idle_and_done();
        op_div = 1'b0; op_signed = 1'b0; a = 32'd6; b = 32'd7;
        start = 1'b1; annul = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_with_annul got %0b want 0", stall); end
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        @(posedge clk); #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL annul_idle_not_accepted got busy %0b want 0", busy); end
        start = 1'b1;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_on_start got %0b want 1", stall); end
        @(posedge clk); #1;
        start = 1'b0;
        repeat (33) @(posedge clk);
        #1 annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        checks++; if (done !== 1'b1) begin errors++; $display("FAIL annul_in_done got done %0b want 1", done); end
        checks++; if (result !== 64'd42) begin errors++; $display("FAIL annul_in_done_result got %h want 2a", result); end
    endtask

    task automatic test_reset_mid();
        int dones;
        op_div = 1'b0; op_signed = 1'b0; a = 32'hFFFFFFFF; b = 32'hFFFFFFFF; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got %0b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL midrst_done got %0b want 0", done); end
        checks++; if (result !== 64'h0) begin errors++; $display("FAIL midrst_result got %h want 0", result); end
        dones = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL midrst_no_done got %0d want 0", dones); end
    endtask

    task automatic test_back_to_back();
        int lat, dones;
        op_div = 1'b0; op_signed = 1'b1; a = 32'hFFFFFFFD; b = 32'd5; start = 1'b1;
        @(posedge clk); #1;
        lat = -1;
        for (int k = 1; k <= 80; k++) begin
            @(posedge clk); #1;
            if (done) begin
                lat = k;
                break;
            end
        end
        start = 1'b0;
        checks++; if (lat !== 34) begin errors++; $display("FAIL held_start_latency got %0d want 34", lat); end
        dones = 0;
        repeat (50) begin
            @(posedge clk); #1;
            if (done) dones++;
        end
        checks++; if (dones !== 0) begin errors++; $display("FAIL held_start_single_done got %0d extra want 0", dones); end
    endtask

    task automatic test_width8();
        int lat;
        logic [15:0] r;
        op_div8 = 1'b0; op_signed8 = 1'b1; a8 = 8'hFC; b8 = 8'hFC; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
        lat = -1; r = '0;
        for (int k = 1; k <= 30; k++) begin
            @(posedge clk); #1;
            if (done8) begin
                lat = k; r = result8;
                break;
            end
        end
        checks++; if (r !== 16'h0010) begin errors++; $display("FAIL w8_mult_result got %h want 0010", r); end
        checks++; if (lat !== 10) begin errors++; $display("FAIL w8_mult_latency got %0d want 10", lat); end
    endtask

    initial begin
        checks = 0; errors = 0;
        rst = 1'b0; start = 1'b0; op_div = 1'b0; op_signed = 1'b0; annul = 1'b0; a = '0; b = '0;
        start8 = 1'b0; op_div8 = 1'b0; op_signed8 = 1'b0; annul8 = 1'b0; a8 = '0; b8 = '0;
        test_reset();
        test_mul();
        test_div();
        test_div_zero();
        test_annul();
        test_annul_idle_and_done();
        test_reset_mid();
        test_back_to_back();
        test_width8();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
